// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: hazard stalls, writeback-port reservation ring and rounding-mode resolution.
// Define RV_FPU_DYN_RND_EN to let rnd=7 select csr_frm; otherwise rnd=7 is illegal.
module fpu_issue_sched #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_FMA  = 5,
  parameter int LAT_MISC = 2,
  parameter int MAXLAT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_fpu_valid,
  input  logic [3:0]  dec_fpu_op,
  input  logic        dec_fpu_op_mod,
  input  logic [2:0]  dec_fpu_rnd,
  input  logic [4:0]  dec_fpu_rs1,
  input  logic [4:0]  dec_fpu_rs2,
  input  logic [4:0]  dec_fpu_rs3,
  input  logic [2:0]  dec_fpu_rs_use,
  input  logic [4:0]  dec_fpu_rd,
  input  logic [2:0]  csr_frm,
  input  logic        flush,
  output logic        fpu_ready,
  output logic        fpu_illegal,
  output logic        fpu_issue_valid,
  output logic [3:0]  fpu_issue_op,
  output logic        fpu_issue_op_mod,
  output logic [2:0]  fpu_issue_rnd,
  output logic        fpu_wb_valid,
  output logic [4:0]  fpu_wb_rd,
  output logic [31:0] fpu_pending,
  output logic        fpu_busy
);
  localparam int LW = $clog2(MAXLAT);

  logic [MAXLAT-1:0] res_p0, res_nxt;
  logic [4:0]        tag_p0  [MAXLAT];
  logic [4:0]        tag_nxt [MAXLAT];
  logic [31:0]       pend_p0, pend_nxt;
  logic [LW-1:0]     lat, lat_m1;
  logic [3:0]        rnd_pack;
  logic [2:0]        rnd_res;
  logic              rnd_ok, hazard, accept;

  function automatic logic [LW-1:0] lat_of(input logic [3:0] op);
    if (op <= 4'd3)      return LW'(LAT_ADD);
    else if (op <= 4'd5) return LW'(LAT_MUL);
    else if (op <= 4'd9) return LW'(LAT_FMA);
    else                 return LW'(LAT_MISC);
  endfunction

  // Rounding resolution returns {legal, mode}.
`ifdef RV_FPU_DYN_RND_EN
  function automatic logic [3:0] resolve_rnd(input logic [2:0] rnd, input logic [2:0] frm);
    logic [2:0] m;
    m = (rnd == 3'd7) ? frm : rnd;
    return {(m <= 3'd4), m};
  endfunction
  assign rnd_pack = resolve_rnd(dec_fpu_rnd, csr_frm);
`else
  function automatic logic [3:0] resolve_rnd(input logic [2:0] rnd);
    return {(rnd <= 3'd4), rnd};
  endfunction
  logic unused_frm;
  assign unused_frm = ^csr_frm;
  assign rnd_pack   = resolve_rnd(dec_fpu_rnd);
`endif

  assign rnd_ok  = rnd_pack[3];
  assign rnd_res = rnd_pack[2:0];

  // Handshake: hazards are judged against registered state only, so no bypass of retiring ops.
  always_comb begin
    lat         = lat_of(dec_fpu_op);
    lat_m1      = lat - LW'(1);
    hazard      = (dec_fpu_rs_use[0] & pend_p0[dec_fpu_rs1])
                | (dec_fpu_rs_use[1] & pend_p0[dec_fpu_rs2])
                | (dec_fpu_rs_use[2] & pend_p0[dec_fpu_rs3])
                | pend_p0[dec_fpu_rd]
                | res_p0[lat];
    fpu_illegal = dec_fpu_valid & ~flush & ~rnd_ok;
    accept      = dec_fpu_valid & ~flush & rnd_ok & ~hazard;
    fpu_ready   = accept | fpu_illegal;
  end

  always_comb begin
    res_nxt = {1'b0, res_p0[MAXLAT-1:1]};
    for (int i = 0; i < MAXLAT - 1; i++) tag_nxt[i] = tag_p0[i+1];
    tag_nxt[MAXLAT-1] = '0;
    pend_nxt = pend_p0;
    if (res_p0[0]) pend_nxt[tag_p0[0]] = 1'b0;
    if (accept) begin
      res_nxt[lat_m1]      = 1'b1;
      tag_nxt[lat_m1]      = dec_fpu_rd;
      pend_nxt[dec_fpu_rd] = 1'b1;
    end
  end

  // Stage p0: reservation ring, pending mask and issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p0           <= '0;
      pend_p0          <= '0;
      fpu_issue_valid  <= 1'b0;
      fpu_issue_op     <= '0;
      fpu_issue_op_mod <= 1'b0;
      fpu_issue_rnd    <= '0;
      for (int i = 0; i < MAXLAT; i++) tag_p0[i] <= '0;
    end else if (flush) begin
      res_p0          <= '0;
      pend_p0         <= '0;
      fpu_issue_valid <= 1'b0;
      for (int i = 0; i < MAXLAT; i++) tag_p0[i] <= '0;
    end else begin
      res_p0          <= res_nxt;
      pend_p0         <= pend_nxt;
      tag_p0          <= tag_nxt;
      fpu_issue_valid <= accept;
      if (accept) begin
        fpu_issue_op     <= dec_fpu_op;
        fpu_issue_op_mod <= dec_fpu_op_mod;
        fpu_issue_rnd    <= rnd_res;
      end
    end
  end

  assign fpu_wb_valid = res_p0[0];
  assign fpu_wb_rd    = tag_p0[0];
  assign fpu_pending  = pend_p0;
  assign fpu_busy     = |pend_p0;
endmodule

// File: tb/tb_fpu_issue_sched.sv
// Scoreboard bench for fpu_issue_sched: directed scenarios plus randomized traffic against an op-list model.
`timescale 1ns/1ps
module tb_fpu_issue_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        dec_fpu_valid, dec_fpu_op_mod, flush;
  logic [3:0]  dec_fpu_op;
  logic [2:0]  dec_fpu_rnd, dec_fpu_rs_use, csr_frm;
  logic [4:0]  dec_fpu_rs1, dec_fpu_rs2, dec_fpu_rs3, dec_fpu_rd;
  logic        fpu_ready, fpu_illegal, fpu_issue_valid, fpu_issue_op_mod, fpu_wb_valid, fpu_busy;
  logic [3:0]  fpu_issue_op;
  logic [2:0]  fpu_issue_rnd;
  logic [4:0]  fpu_wb_rd;
  logic [31:0] fpu_pending;

  fpu_issue_sched dut (
    .clk(clk), .rst(rst), .dec_fpu_valid(dec_fpu_valid), .dec_fpu_op(dec_fpu_op),
    .dec_fpu_op_mod(dec_fpu_op_mod), .dec_fpu_rnd(dec_fpu_rnd), .dec_fpu_rs1(dec_fpu_rs1),
    .dec_fpu_rs2(dec_fpu_rs2), .dec_fpu_rs3(dec_fpu_rs3), .dec_fpu_rs_use(dec_fpu_rs_use),
    .dec_fpu_rd(dec_fpu_rd), .csr_frm(csr_frm), .flush(flush), .fpu_ready(fpu_ready),
    .fpu_illegal(fpu_illegal), .fpu_issue_valid(fpu_issue_valid), .fpu_issue_op(fpu_issue_op),
    .fpu_issue_op_mod(fpu_issue_op_mod), .fpu_issue_rnd(fpu_issue_rnd), .fpu_wb_valid(fpu_wb_valid),
    .fpu_wb_rd(fpu_wb_rd), .fpu_pending(fpu_pending), .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

`ifdef RV_FPU_DYN_RND_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  typedef struct {int rd; int acc; int due; int fin;} fop_t;
  typedef struct {int cy; int op; int mdf; int rnd;} iss_t;
  typedef struct {int cy; int rd;} wbx_t;
  typedef struct {bit v; int op; bit mdf; int rnd; int rs1; int rs2; int rs3; int rsu; int rd; int frm; bit fl;} req_t;

  fop_t fl_q[$];
  iss_t iss_q[$];
  wbx_t wb_q[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   mon_en = 1'b0;
  iss_t mon_iss;
  wbx_t mon_wb;
  logic [31:0] mon_pm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(int op);
    if (op < 4) return 3;
    if (op < 6) return 4;
    if (op < 10) return 5;
    return 2;
  endfunction

  function automatic int resolve(int rnd, int frm, output bit ok);
    int m;
    m  = (DYN && rnd == 7) ? frm : rnd;
    ok = (m <= 4);
    return m;
  endfunction

  // A register is pending in cycle n if an op accepted before n has not yet retired or been flushed.
  function automatic logic [31:0] pend_at(int n);
    logic [31:0] m;
    m = '0;
    foreach (fl_q[i]) if (fl_q[i].acc < n && n <= fl_q[i].fin) m[fl_q[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic bit slot_taken(int d);
    foreach (fl_q[i]) if (fl_q[i].due == d && fl_q[i].fin == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic req_t mk(int op, int rd, int rs1 = 0, int rs2 = 0, int rs3 = 0, int rsu = 0,
                              int rnd = 0, int frm = 0);
    req_t r;
    r.v = 1'b1; r.op = op; r.mdf = 1'b0; r.rnd = rnd; r.rs1 = rs1; r.rs2 = rs2; r.rs3 = rs3;
    r.rsu = rsu; r.rd = rd; r.frm = frm; r.fl = 1'b0;
    return r;
  endfunction

  function automatic req_t idle_req(bit fl = 1'b0);
    req_t r;
    r = mk(0, 0);
    r.v = 1'b0; r.fl = fl;
    return r;
  endfunction

  task automatic drive(input req_t r, output bit acc);
    bit ok, hz, e_ill, e_rdy;
    int rr, l, k;
    logic [31:0] pm;
    fop_t keep[$];
    iss_t is;
    wbx_t w;
    fop_t f;
    @(posedge clk); #1;
    dec_fpu_valid = r.v; dec_fpu_op = 4'(r.op); dec_fpu_op_mod = r.mdf; dec_fpu_rnd = 3'(r.rnd);
    dec_fpu_rs1 = 5'(r.rs1); dec_fpu_rs2 = 5'(r.rs2); dec_fpu_rs3 = 5'(r.rs3);
    dec_fpu_rs_use = 3'(r.rsu); dec_fpu_rd = 5'(r.rd); csr_frm = 3'(r.frm); flush = r.fl;
    foreach (fl_q[i]) if (fl_q[i].fin >= cyc) keep.push_back(fl_q[i]);
    fl_q = keep;
    #1;
    rr = resolve(r.rnd, r.frm, ok);
    l  = lat_of(r.op);
    pm = pend_at(cyc);
    hz = (r.rsu[0] && pm[r.rs1]) || (r.rsu[1] && pm[r.rs2]) || (r.rsu[2] && pm[r.rs3]) ||
         pm[r.rd] || slot_taken(cyc + l);
    e_ill = r.v && !r.fl && !ok;
    e_rdy = r.v && !r.fl && (!ok || !hz);
    chk("ready", fpu_ready, e_rdy);
    chk("illegal", fpu_illegal, e_ill);
    acc = e_rdy && ok;
    if (acc) begin
      f.rd = r.rd; f.acc = cyc; f.due = cyc + l; f.fin = cyc + l;
      fl_q.push_back(f);
      is.cy = cyc + 1; is.op = r.op; is.mdf = r.mdf; is.rnd = rr;
      iss_q.push_back(is);
      w.cy = cyc + l; w.rd = r.rd;
      k = 0;
      while (k < wb_q.size() && wb_q[k].cy < w.cy) k++;
      wb_q.insert(k, w);
    end
    if (r.fl) begin
      foreach (fl_q[i]) if (fl_q[i].fin > cyc) fl_q[i].fin = cyc;
      while (wb_q.size() > 0 && wb_q[$].cy > cyc) void'(wb_q.pop_back());
    end
  endtask

  task automatic do_reset();
    bit acc;
    @(posedge clk); #1;
    dec_fpu_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    fl_q.delete(); iss_q.delete(); wb_q.delete();
    #2;
    chk("rst_issue_valid", fpu_issue_valid, 0);
    chk("rst_wb_valid", fpu_wb_valid, 0);
    chk("rst_pending", fpu_pending, 0);
    chk("rst_busy", fpu_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(idle_req(), acc);
  endtask

  // Monitor: pops expected issue/writeback events when the DUT presents them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_mon_issue", fpu_issue_valid, 0);
        chk("rst_mon_wb", fpu_wb_valid, 0);
        chk("rst_mon_pend", fpu_pending, 0);
      end else begin
        if (fpu_issue_valid) begin
          if (iss_q.size() == 0) chk("issue_spurious", fpu_issue_valid, 0);
          else begin
            mon_iss = iss_q.pop_front();
            chk("issue_cycle", cyc, mon_iss.cy);
            chk("issue_op", fpu_issue_op, mon_iss.op);
            chk("issue_mod", fpu_issue_op_mod, mon_iss.mdf);
            chk("issue_rnd", fpu_issue_rnd, mon_iss.rnd);
          end
        end else if (iss_q.size() > 0 && iss_q[0].cy <= cyc) begin
          chk("issue_missing", fpu_issue_valid, 1);
          void'(iss_q.pop_front());
        end
        if (fpu_wb_valid) begin
          if (wb_q.size() == 0) chk("wb_spurious", fpu_wb_valid, 0);
          else begin
            mon_wb = wb_q.pop_front();
            chk("wb_cycle", cyc, mon_wb.cy);
            chk("wb_rd", fpu_wb_rd, mon_wb.rd);
          end
        end else if (wb_q.size() > 0 && wb_q[0].cy <= cyc) begin
          chk("wb_missing", fpu_wb_valid, 1);
          void'(wb_q.pop_front());
        end
        mon_pm = pend_at(cyc);
        chk("pending", fpu_pending, mon_pm);
        chk("busy", fpu_busy, |mon_pm);
      end
    end
  end

  initial begin
    bit acc, c_ill;
    int t, acc_cyc;
    req_t r;
    rst = 1'b1; dec_fpu_valid = 1'b0; dec_fpu_op = '0; dec_fpu_op_mod = 1'b0; dec_fpu_rnd = '0;
    dec_fpu_rs1 = '0; dec_fpu_rs2 = '0; dec_fpu_rs3 = '0; dec_fpu_rs_use = '0; dec_fpu_rd = '0;
    csr_frm = '0; flush = 1'b0;
    @(posedge clk); #2;
    mon_en = 1'b1;
    do_reset();
    repeat (3) drive(idle_req(), acc);

    // Add to f3: issue at t+1, writeback at t+3, pending clear at t+4.
    drive(mk(0, 3), acc); t = cyc;
    for (int i = 1; i <= 4; i++) begin
      drive(idle_req(), acc);
      if (i == 1) chk("add_issue_valid", fpu_issue_valid, 1);
      if (i == 3) begin chk("add_wb_valid", fpu_wb_valid, 1); chk("add_wb_rd", fpu_wb_rd, 3); end
      if (i == 4) chk("add_pend3_clear", fpu_pending[3], 0);
    end
    repeat (4) drive(idle_req(), acc);

    // Writeback-port conflict between FMA and a later add.
    drive(mk(6, 10), acc);
    drive(idle_req(), acc);
    drive(mk(0, 11), acc); chk("port_stall", fpu_ready, 0);
    drive(mk(0, 11), acc); chk("port_accept", fpu_ready, 1);
    drive(idle_req(), acc);
    drive(idle_req(), acc); chk("port_wb1", fpu_wb_rd, 10); chk("port_wb1_v", fpu_wb_valid, 1);
    drive(idle_req(), acc); chk("port_wb2", fpu_wb_rd, 11); chk("port_wb2_v", fpu_wb_valid, 1);
    repeat (4) drive(idle_req(), acc);

    // RAW on f7 behind a multiply.
    drive(mk(4, 7), acc); t = cyc; acc_cyc = -1;
    for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
      drive(mk(0, 12, 1, 7, 0, 3'b010), acc);
      if (fpu_ready) acc_cyc = cyc;
    end
    chk("raw_accept_delay", acc_cyc - t, 5);
    repeat (6) drive(idle_req(), acc);

    // Flush one cycle after an FMA.
    drive(mk(6, 20), acc);
    drive(idle_req(1'b1), acc); chk("flush_ready", fpu_ready, 0);
    drive(idle_req(), acc); chk("flush_pend", fpu_pending, 0); chk("flush_issue", fpu_issue_valid, 0);
    drive(idle_req(), acc);
    drive(idle_req(), acc);
    drive(idle_req(), acc); chk("flush_no_wb", fpu_wb_valid, 0);
    repeat (2) drive(idle_req(), acc);

    // Rounding modes.
    drive(mk(0, 4, 0, 0, 0, 0, 5), acc);
    chk("rnd5_ready", fpu_ready, 1); chk("rnd5_illegal", fpu_illegal, 1);
    drive(idle_req(), acc); chk("rnd5_no_issue", fpu_issue_valid, 0);
    drive(mk(1, 5, 0, 0, 0, 0, 7, 2), acc); c_ill = fpu_illegal;
    drive(idle_req(), acc);
    if (DYN) begin
      chk("rnd7_not_illegal", c_ill, 0);
      chk("rnd7_issue_rnd", fpu_issue_rnd, 2);
    end else begin
      chk("rnd7_illegal", c_ill, 1);
      chk("rnd7_no_issue", fpu_issue_valid, 0);
    end
    repeat (6) drive(idle_req(), acc);

    // Reset while ops are in flight: none of them may write back.
    drive(mk(6, 1), acc);
    drive(mk(4, 2), acc);
    do_reset();
    repeat (8) drive(idle_req(), acc);

    // Randomized traffic on a small register set to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      r = mk($urandom % 16, $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 8,
             ($urandom % 8 < 6) ? $urandom % 5 : 5 + $urandom % 3, $urandom % 8);
      r.mdf = $urandom % 2;
      r.v   = ($urandom % 10) < 7;
      r.fl  = ($urandom % 40) == 0;
      drive(r, acc);
    end
    repeat (10) drive(idle_req(), acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
